// File: rtl/vector_alu_pkg.sv
// Shared types and flag indices for the folded vector ALU.
package vector_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-element ALU with optional saturating add/sub and {N,Z,C,V} flags.
module vector_lane_alu
    import vector_alu_pkg::*;
#(
    parameter int unsigned ELEM_W = 16
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  alu_op_e           op,
    input  logic              sat,
    output logic [ELEM_W-1:0] y,
    output logic [3:0]        flags
);

    localparam int unsigned MSB  = ELEM_W - 1;
    localparam int unsigned SH_W = $clog2(ELEM_W);

    logic [ELEM_W:0]   sum_ext;
    logic [ELEM_W:0]   diff_ext;
    logic [SH_W-1:0]   sh_amt;
    logic              carry;
    logic              ovf;

    // SUB as a + ~b + 1 so the carry out is directly the no-borrow flag.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + (ELEM_W + 1)'(1);
    assign sh_amt   = b[SH_W-1:0];

    always_comb begin
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_ADD: begin
                y     = sum_ext[ELEM_W-1:0];
                carry = sum_ext[ELEM_W];
                ovf   = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                y     = diff_ext[ELEM_W-1:0];
                carry = diff_ext[ELEM_W];
                ovf   = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << sh_amt;
            ALU_SRA: y = ELEM_W'($signed(a) >>> sh_amt);
            ALU_MUL: y = ELEM_W'(a * b);
            default: y = '0;
        endcase

        // Overflow direction always follows the sign of a for both add and sub.
        if (sat && ovf && ((op == ALU_ADD) || (op == ALU_SUB))) begin
            y = a[MSB] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
        end

        flags         = '0;
        flags[FLAG_N] = y[MSB];
        flags[FLAG_Z] = (y == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/vector_alu_folded.sv
// Multi-cycle vector ALU: LANES lane ALUs fold a NUM_ELEMS vector over NUM_ELEMS/LANES passes.
module vector_alu_folded
    import vector_alu_pkg::*;
#(
    parameter  int unsigned ELEM_W    = 16,
    parameter  int unsigned NUM_ELEMS = 16,
    parameter  int unsigned LANES     = 4,
    localparam int unsigned VEC_W     = NUM_ELEMS * ELEM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VEC_W-1:0]       A,
    input  logic [VEC_W-1:0]       B,
    input  logic [2:0]             ALUControl,
    input  logic                   sat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VEC_W-1:0]       result,
    output logic [4*NUM_ELEMS-1:0] flags
);

    localparam int unsigned P     = NUM_ELEMS / LANES;
    localparam int unsigned CNT_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

    if ((NUM_ELEMS % LANES) != 0) begin : g_cfg_err
        $error("vector_alu_folded: NUM_ELEMS must be a multiple of LANES");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic               load_en;
    logic               wr_en;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ELEM_W-1:0]  a_q      [NUM_ELEMS];
    logic [ELEM_W-1:0]  b_q      [NUM_ELEMS];
    alu_op_e            op_q;
    logic               sat_q;
    logic [ELEM_W-1:0]  result_q [NUM_ELEMS];
    logic [3:0]         flags_q  [NUM_ELEMS];

    logic [IDX_W-1:0]   lane_idx [LANES];
    logic [ELEM_W-1:0]  lane_y   [LANES];
    logic [3:0]         lane_f   [LANES];

    // Lane l works on element pass*LANES + l of the latched operands.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(32'(pass_q) * LANES + 32'(l));

        vector_lane_alu #(.ELEM_W(ELEM_W)) u_lane (
            .a     (a_q[lane_idx[l]]),
            .b     (b_q[lane_idx[l]]),
            .op    (op_q),
            .sat   (sat_q),
            .y     (lane_y[l]),
            .flags (lane_f[l])
        );
    end

    for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_out
        assign result[e*ELEM_W +: ELEM_W] = result_q[e];
        assign flags[4*e +: 4]            = flags_q[e];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    // Next-state and datapath enables.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        load_en = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_en = 1'b1;
                    pass_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wr_en = 1'b1;
                if (pass_q == CNT_W'(P - 1)) begin
                    pass_d  = '0;
                    state_d = DONE;
                end else begin
                    pass_d = pass_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_q        <= ALU_ADD;
            sat_q       <= 1'b0;
            for (int e = 0; e < NUM_ELEMS; e++) begin
                a_q[e]      <= '0;
                b_q[e]      <= '0;
                result_q[e] <= '0;
                flags_q[e]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            if (load_en) begin
                op_q  <= alu_op_e'(ALUControl);
                sat_q <= sat;
                for (int e = 0; e < NUM_ELEMS; e++) begin
                    a_q[e] <= A[e*ELEM_W +: ELEM_W];
                    b_q[e] <= B[e*ELEM_W +: ELEM_W];
                end
            end
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    result_q[lane_idx[l]] <= lane_y[l];
                    flags_q[lane_idx[l]]  <= lane_f[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_folded.sv
// Bench for vector_alu_folded: default LANES=4 and LANES=16 instances driven side by side.
module tb_vector_alu_folded;

    localparam int unsigned EW = 16;
    localparam int unsigned NE = 16;
    localparam int unsigned VW = NE * EW;
    localparam int unsigned FW = 4 * NE;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [VW-1:0] A, B;
    logic [2:0]    alu_ctrl;
    logic          sat;
    logic          out_ready;

    logic          in_ready4, out_valid4, in_ready16, out_valid16;
    logic [VW-1:0] result4, result16;
    logic [FW-1:0] flags4, flags16;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    vector_alu_folded #(.ELEM_W(EW), .NUM_ELEMS(NE), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .A(A), .B(B), .ALUControl(alu_ctrl), .sat(sat),
        .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .flags(flags4)
    );

    vector_alu_folded #(.ELEM_W(EW), .NUM_ELEMS(NE), .LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .A(A), .B(B), .ALUControl(alu_ctrl), .sat(sat),
        .out_valid(out_valid16), .out_ready(out_ready),
        .result(result16), .flags(flags16)
    );

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        s;
        logic [15:0] exp_y;
        logic [3:0]  exp_f;
    } vec_t;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: element semantics from plain integer arithmetic.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                  input logic s, output logic [15:0] y, output logic [3:0] f);
        longint ua, ub, sa, sb, uf, sf;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        y = '0;
        case (op)
            3'd0: begin
                uf = ua + ub; sf = sa + sb;
                c = (uf > 65535);
                v = (sf > 32767) || (sf < -32768);
                y = 16'(uf);
                if (s && v) y = (sf > 0) ? 16'h7fff : 16'h8000;
            end
            3'd1: begin
                uf = ua - ub; sf = sa - sb;
                c = (ua >= ub);
                v = (sf > 32767) || (sf < -32768);
                y = 16'(uf);
                if (s && v) y = (sf > 0) ? 16'h7fff : 16'h8000;
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = 16'(ua << b[3:0]);
            3'd6: y = 16'(sa >>> b[3:0]);
            default: y = 16'(sa * sb);
        endcase
        f = {y[15], (y == 16'h0), c, v};
    endfunction

    function automatic logic [15:0] rnd_elem();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0: return 16'h7fff;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    // Present one vector, then wait (bounded) for out_valid on both instances.
    task automatic run_vec(input logic [VW-1:0] av, input logic [VW-1:0] bv,
                           input logic [2:0] op, input logic s, input string name);
        int lat4, lat16;
        @(negedge clk);
        A = av; B = bv; alu_ctrl = op; sat = s; in_valid = 1'b1;
        check({name, "_in_ready4"}, VW'(in_ready4), VW'(1));
        check({name, "_in_ready16"}, VW'(in_ready16), VW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = {8{$urandom}}; B = {8{$urandom}}; alu_ctrl = 3'($urandom); sat = ~s;
        lat4 = 0; lat16 = 0;
        for (int c = 1; c <= 20 && (lat4 == 0 || lat16 == 0); c++) begin
            @(posedge clk); #1;
            if (lat4 == 0 && out_valid4) lat4 = c;
            if (lat16 == 0 && out_valid16) lat16 = c;
        end
        check({name, "_lat4"}, VW'(lat4), VW'(4));
        check({name, "_lat16"}, VW'(lat16), VW'(1));
    endtask

    task automatic check_outputs(input string name, input logic [VW-1:0] er, input logic [FW-1:0] ef);
        check({name, "_res4"}, result4, er);
        check({name, "_flg4"}, VW'(flags4), VW'(ef));
        check({name, "_res16"}, result16, er);
        check({name, "_flg16"}, VW'(flags16), VW'(ef));
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_ov4_drop"}, VW'(out_valid4), VW'(0));
        check({name, "_ir4_back"}, VW'(in_ready4), VW'(1));
        check({name, "_ov16_drop"}, VW'(out_valid16), VW'(0));
        check({name, "_ir16_back"}, VW'(in_ready16), VW'(1));
    endtask

    vec_t          vt [13];
    logic [VW-1:0] av, bv, er;
    logic [FW-1:0] ef;
    logic [15:0]   ye;
    logic [3:0]    fe;
    logic [2:0]    rop;
    logic          rs;

    initial begin
        vt[0]  = '{"add_wrap",    16'h7fff, 16'h0001, 3'd0, 1'b0, 16'h8000, 4'b1001};
        vt[1]  = '{"add_sat",     16'h7fff, 16'h0001, 3'd0, 1'b1, 16'h7fff, 4'b0001};
        vt[2]  = '{"sub_sat",     16'h8000, 16'h0001, 3'd1, 1'b1, 16'h8000, 4'b1011};
        vt[3]  = '{"sub_wrap",    16'h8000, 16'h0001, 3'd1, 1'b0, 16'h7fff, 4'b0011};
        vt[4]  = '{"add_negsat",  16'h8000, 16'h8000, 3'd0, 1'b1, 16'h8000, 4'b1011};
        vt[5]  = '{"add_negwrap", 16'h8000, 16'h8000, 3'd0, 1'b0, 16'h0000, 4'b0111};
        vt[6]  = '{"sub_borrow",  16'h0005, 16'h0007, 3'd1, 1'b0, 16'hfffe, 4'b1000};
        vt[7]  = '{"sll",         16'h0003, 16'h0004, 3'd5, 1'b0, 16'h0030, 4'b0000};
        vt[8]  = '{"mul",         16'h0003, 16'h0004, 3'd7, 1'b1, 16'h000c, 4'b0000};
        vt[9]  = '{"sra",         16'hf000, 16'h0004, 3'd6, 1'b0, 16'hff00, 4'b1000};
        vt[10] = '{"sll_hibits",  16'h0001, 16'h0014, 3'd5, 1'b0, 16'h0010, 4'b0000};
        vt[11] = '{"and",         16'hf0f0, 16'hff00, 3'd2, 1'b0, 16'hf000, 4'b1000};
        vt[12] = '{"xor_zero",    16'h1234, 16'h1234, 3'd4, 1'b1, 16'h0000, 4'b0100};

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; alu_ctrl = '0; sat = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready4", VW'(in_ready4), VW'(1));
        check("rst_out_valid4", VW'(out_valid4), VW'(0));
        check("rst_in_ready16", VW'(in_ready16), VW'(1));
        check("rst_out_valid16", VW'(out_valid16), VW'(0));
        check_outputs("rst", '0, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec({NE{vt[i].a}}, {NE{vt[i].b}}, vt[i].op, vt[i].s, vt[i].name);
            check_outputs(vt[i].name, {NE{vt[i].exp_y}}, {NE{vt[i].exp_f}});
            release_out(vt[i].name);
        end

        // Distinct per-element operands exercise the lane/pass mapping.
        for (int e = 0; e < NE; e++) begin
            av[e*EW +: EW] = 16'(e);
        end
        run_vec(av, av, 3'd1, 1'b0, "sub_distinct");
        check_outputs("sub_distinct", '0, {NE{4'b0110}});
        release_out("sub_distinct");

        for (int e = 0; e < NE; e++) begin
            av[e*EW +: EW] = 16'(e * 16'h1111);
            bv[e*EW +: EW] = 16'(e + 1);
        end
        run_vec(av, bv, 3'd0, 1'b0, "add_distinct");
        for (int e = 0; e < NE; e++) begin
            model(av[e*EW +: EW], bv[e*EW +: EW], 3'd0, 1'b0, ye, fe);
            er[e*EW +: EW] = ye;
            ef[4*e +: 4]   = fe;
        end
        check_outputs("add_distinct", er, ef);

        // Backpressure: hold DONE, offer a new vector that must be ignored.
        @(negedge clk);
        in_valid = 1'b1; A = {8{$urandom}}; B = {8{$urandom}}; alu_ctrl = 3'd4;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_res4", result4, er);
            check("bp_flg4", VW'(flags4), VW'(ef));
            check("bp_res16", result16, er);
            check("bp_ir4", VW'(in_ready4), VW'(0));
            check("bp_ov4", VW'(out_valid4), VW'(1));
            check("bp_ir16", VW'(in_ready16), VW'(0));
            check("bp_ov16", VW'(out_valid16), VW'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_once_ov4", VW'(out_valid4), VW'(0));
        check("bp_once_ov16", VW'(out_valid16), VW'(0));
        check("bp_once_ir4", VW'(in_ready4), VW'(1));
        check("bp_once_ir16", VW'(in_ready16), VW'(1));

        // Reset during pass 2 of the folded instance.
        @(negedge clk);
        A = {NE{16'h1234}}; B = {NE{16'h0101}}; alu_ctrl = 3'd0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_busy_ir4", VW'(in_ready4), VW'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ir4", VW'(in_ready4), VW'(1));
        check("midrst_ov4", VW'(out_valid4), VW'(0));
        check("midrst_ir16", VW'(in_ready16), VW'(1));
        check("midrst_ov16", VW'(out_valid16), VW'(0));
        check_outputs("midrst", '0, '0);
        run_vec({NE{16'h0003}}, {NE{16'h0004}}, 3'd7, 1'b0, "post_rst_mul");
        check_outputs("post_rst_mul", {NE{16'h000c}}, {NE{4'b0000}});
        release_out("post_rst_mul");

        // Random vectors against the reference model.
        for (int t = 0; t < 30; t++) begin
            rop = 3'($urandom);
            rs  = 1'($urandom);
            for (int e = 0; e < NE; e++) begin
                av[e*EW +: EW] = rnd_elem();
                bv[e*EW +: EW] = rnd_elem();
                model(av[e*EW +: EW], bv[e*EW +: EW], rop, rs, ye, fe);
                er[e*EW +: EW] = ye;
                ef[4*e +: 4]   = fe;
            end
            run_vec(av, bv, rop, rs, "rand");
            check_outputs("rand", er, ef);
            release_out("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
